issue_select_ctrl: RTL and testbench

- Scheduler for a bank of issue slots; allocates free slots to dispatched micro-ops and selects one ready slot per cycle for issue.
- Collects per-slot request lines, picks the oldest requester via an age matrix, returns grant/clear to the winning slot.
- Sits between the dispatch stage and the issue slots, upstream of the functional-unit port.

---
 rtl/issue_select_if.sv | 33 +++
 rtl/issue_select_ctrl.sv | 102 ++++++++++
 tb/tb_issue_select_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_select_if.sv
// Dispatch and issue-slot signal bundle for issue_select_ctrl.
// Handshake: a dispatch fires on any rising edge where dis_valid & dis_ready are both high; dis_slot names the slot written.
interface issue_select_if #(
    parameter int NUM_SLOTS = 8
);
    logic                 dis_valid;
    logic                 dis_ready;
    logic [NUM_SLOTS-1:0] dis_slot;
    logic [NUM_SLOTS-1:0] slot_request;
    logic [NUM_SLOTS-1:0] slot_grant;
    logic                 grant_valid;
    logic [NUM_SLOTS-1:0] slot_clear;

    modport master (
        output dis_valid,
        output slot_request,
        input  dis_ready,
        input  dis_slot,
        input  slot_grant,
        input  grant_valid,
        input  slot_clear
    );

    modport slave (
        input  dis_valid,
        input  slot_request,
        output dis_ready,
        output dis_slot,
        output slot_grant,
        output grant_valid,
        output slot_clear
    );
endinterface

// File: rtl/issue_select_ctrl.sv
// Issue-slot scheduler: allocates the lowest free slot on dispatch and grants
// the oldest occupied requester each cycle using an age matrix.
module issue_select_ctrl #(
    parameter int NUM_SLOTS = 8,
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    issue_select_if.slave    bus,
    input  logic             fu_stall,
    input  logic             flush,
    output logic [CNT_W-1:0] occ_count,
    output logic             full,
    output logic             empty
);

    logic [NUM_SLOTS-1:0]                occupied;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age;       // age[i][j]: slot i older than slot j
    logic [NUM_SLOTS-1:0]                occupied_n;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age_n;
    logic [CNT_W-1:0]                    occ_count_n;

    logic [NUM_SLOTS-1:0] elig;
    logic [NUM_SLOTS-1:0] blocked;
    logic [NUM_SLOTS-1:0] winner;
    logic [NUM_SLOTS-1:0] free_sel;
    logic [NUM_SLOTS-1:0] survivors;
    logic                 any_free;
    logic                 fire;

    assign elig = bus.slot_request & occupied;

    // A slot loses if any other eligible slot is older than it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (elig[j] && age[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        winner = elig & ~blocked;
    end

    always_comb begin
        free_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
        end
    end

    assign any_free        = |(~occupied);
    assign bus.dis_ready   = any_free && !flush;
    assign bus.dis_slot    = bus.dis_ready ? free_sel : '0;
    assign fire            = bus.dis_valid && bus.dis_ready;
    assign bus.slot_grant  = (fu_stall || flush) ? '0 : winner;
    assign bus.grant_valid = |bus.slot_grant;
    assign bus.slot_clear  = flush ? occupied : bus.slot_grant;
    assign survivors       = occupied & ~bus.slot_grant;

    // A newly allocated slot is younger than every slot that survives this edge.
    always_comb begin
        occupied_n  = survivors | (fire ? bus.dis_slot : '0);
        occ_count_n = occ_count + CNT_W'(fire) - CNT_W'(bus.grant_valid);
        age_n       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                age_n[i][j] = age[i][j] && !bus.slot_grant[i] && !bus.slot_grant[j];
                if (fire && bus.dis_slot[j] && survivors[i]) begin
                    age_n[i][j] = 1'b1;
                end
                if (fire && bus.dis_slot[i]) begin
                    age_n[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupied  <= '0;
            age       <= '0;
            occ_count <= '0;
        end else if (flush) begin
            occupied  <= '0;
            age       <= '0;
            occ_count <= '0;
        end else begin
            occupied  <= occupied_n;
            age       <= age_n;
            occ_count <= occ_count_n;
        end
    end

    assign full  = (occ_count == CNT_W'(NUM_SLOTS));
    assign empty = (occ_count == '0);

endmodule

// File: tb/tb_issue_select_ctrl.sv
// Bench for issue_select_ctrl: oldest-first list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_issue_select_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset;
    logic          fu_stall;
    logic          flush;
    logic [CW-1:0] occ_count;
    logic          full;
    logic          empty;

    issue_select_if #(.NUM_SLOTS(N)) bus ();

    issue_select_ctrl #(.NUM_SLOTS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fu_stall  (fu_stall),
        .flush     (flush),
        .occ_count (occ_count),
        .full      (full),
        .empty     (empty)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // scoreboard: occupied slots listed oldest first
    logic [2:0]   exp_q[$];
    logic [N-1:0] occ_m;
    logic [N-1:0] e_slot, e_grant, e_clear;
    logic         e_ready;
    int           lf, gidx;

    always @(negedge clk) begin
        if (reset) begin
            occ_m = '0;
            exp_q.delete();
        end
        lf = -1;
        for (int i = 0; i < N; i++) if (!occ_m[i] && lf < 0) lf = i;
        e_ready = (lf >= 0) && !flush;
        e_slot  = '0;
        if (e_ready) e_slot[lf] = 1'b1;
        e_grant = '0;
        gidx    = -1;
        if (!fu_stall && !flush) begin
            for (int q = 0; q < exp_q.size(); q++) begin
                if (bus.slot_request[exp_q[q]] && gidx < 0) begin
                    gidx = q;
                    e_grant[exp_q[q]] = 1'b1;
                end
            end
        end
        e_clear = flush ? occ_m : e_grant;

        chk("m_dis_ready",   32'(bus.dis_ready),   32'(e_ready));
        chk("m_dis_slot",    32'(bus.dis_slot),    32'(e_slot));
        chk("m_slot_grant",  32'(bus.slot_grant),  32'(e_grant));
        chk("m_grant_valid", 32'(bus.grant_valid), 32'(e_grant != 0));
        chk("m_slot_clear",  32'(bus.slot_clear),  32'(e_clear));
        chk("m_occ_count",   32'(occ_count),       32'(exp_q.size()));
        chk("m_full",        32'(full),            32'(exp_q.size() == N));
        chk("m_empty",       32'(empty),           32'(exp_q.size() == 0));

        if (!reset) begin
            if (flush) begin
                occ_m = '0;
                exp_q.delete();
            end else begin
                if (gidx >= 0) begin
                    occ_m[exp_q[gidx]] = 1'b0;
                    exp_q.delete(gidx);
                end
                if (bus.dis_valid && e_ready) begin
                    occ_m[lf] = 1'b1;
                    exp_q.push_back(3'(lf));
                end
            end
        end
    end

    // driver: apply inputs just after a rising edge, return at the following falling edge
    task automatic cycle(input logic dv, input logic [N-1:0] req, input logic st, input logic fl);
        @(posedge clk);
        #1;
        bus.dis_valid    = dv;
        bus.slot_request = req;
        fu_stall         = st;
        flush            = fl;
        @(negedge clk);
    endtask

    initial begin
        reset            = 1'b1;
        bus.dis_valid    = 1'b0;
        bus.slot_request = '0;
        fu_stall         = 1'b0;
        flush            = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dis_ready", 32'(bus.dis_ready), 32'h1);
        chk("rst_dis_slot",  32'(bus.dis_slot),  32'h01);
        chk("rst_empty",     32'(empty),         32'h1);
        chk("rst_full",      32'(full),          32'h0);
        chk("rst_grant",     32'(bus.slot_grant), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // three dispatches, no requests
        cycle(1, 8'h00, 0, 0); chk("d1_slot", 32'(bus.dis_slot), 32'h01);
        cycle(1, 8'h00, 0, 0); chk("d2_slot", 32'(bus.dis_slot), 32'h02);
        cycle(1, 8'h00, 0, 0); chk("d3_slot", 32'(bus.dis_slot), 32'h04);
        cycle(0, 8'h06, 0, 0);
        chk("d_occ3",      32'(occ_count),      32'd3);
        chk("d_not_empty", 32'(empty),          32'h0);
        chk("g_oldest",    32'(bus.slot_grant), 32'h02);
        chk("g_clear",     32'(bus.slot_clear), 32'h02);
        cycle(0, 8'h00, 0, 0); chk("g_occ2", 32'(occ_count), 32'd2);

        // fill remaining six slots: 1,3,4,5,6,7
        for (int k = 0; k < 6; k++) cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h08, 0, 0);
        chk("f_full",      32'(full),           32'h1);
        chk("f_not_ready", 32'(bus.dis_ready),  32'h0);
        chk("f_slot_zero", 32'(bus.dis_slot),   32'h0);
        chk("f_grant3",    32'(bus.slot_grant), 32'h08);
        cycle(0, 8'h00, 0, 0);
        chk("f_refill3", 32'(bus.dis_slot), 32'h08);
        chk("f_occ7",    32'(occ_count),    32'd7);
        cycle(1, 8'h00, 0, 0);

        // free slot 0, refill it, then it must lose to slot 1
        cycle(0, 8'h01, 0, 0); chk("r_grant0", 32'(bus.slot_grant), 32'h01);
        cycle(1, 8'h00, 0, 0); chk("r_slot0",  32'(bus.dis_slot),   32'h01);
        cycle(0, 8'h03, 0, 0); chk("r_grant1", 32'(bus.slot_grant), 32'h02);

        // fu_stall suppresses grants
        cycle(0, 8'hFF, 1, 0);
        chk("s_grant0",  32'(bus.slot_grant),  32'h0);
        chk("s_gvalid0", 32'(bus.grant_valid), 32'h0);
        chk("s_occ7",    32'(occ_count),       32'd7);
        cycle(0, 8'hFF, 0, 0);
        chk("s_occ_hold", 32'(occ_count),      32'd7);
        chk("s_grant2",   32'(bus.slot_grant), 32'h04);

        // down to five slots (0,3,5,6,7), then flush with dispatch and requests
        cycle(0, 8'h10, 0, 0); chk("x_grant4", 32'(bus.slot_grant), 32'h10);
        cycle(0, 8'h00, 0, 0); chk("x_occ5",   32'(occ_count),      32'd5);
        cycle(1, 8'hFF, 0, 1);
        chk("x_clear",    32'(bus.slot_clear), 32'hE9);
        chk("x_grant",    32'(bus.slot_grant), 32'h0);
        chk("x_notready", 32'(bus.dis_ready),  32'h0);
        cycle(0, 8'h00, 0, 0);
        chk("x_occ0",  32'(occ_count),    32'd0);
        chk("x_empty", 32'(empty),        32'h1);
        chk("x_slot0", 32'(bus.dis_slot), 32'h01);

        // simultaneous dispatch and grant
        cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h01, 0, 0);
        chk("sd_grant0", 32'(bus.slot_grant), 32'h01);
        chk("sd_slot2",  32'(bus.dis_slot),   32'h04);
        cycle(0, 8'h06, 0, 0);
        chk("sd_occ2",   32'(occ_count),      32'd2);
        chk("sd_grant1", 32'(bus.slot_grant), 32'h02);
        cycle(0, 8'h00, 0, 0);

        // asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_occ0",  32'(occ_count),    32'd0);
        chk("ar_empty", 32'(empty),        32'h1);
        chk("ar_slot0", 32'(bus.dis_slot), 32'h01);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1, 8'h00, 0, 0); chk("ar_redisp", 32'(bus.dis_slot), 32'h01);
        cycle(0, 8'h01, 0, 0); chk("ar_grant",  32'(bus.slot_grant), 32'h01);
        cycle(0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
